sort_sequencer: RTL and testbench



---
 rtl/sort_sequencer_if.sv | 28 ++
 rtl/sort_sequencer.sv | 138 +++++++++++++
 tb/tb_sort_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_sequencer_if.sv
// Control/status bundle between the sort sequencer and the register-file/ALU datapath.
// The master side is the sequencer; the slave side is the datapath plus whoever issues start.
interface sort_sequencer_if;
    logic        start;
    logic        mayor;
    logic [14:0] o_signal;
    logic        busy;
    logic        done;
    logic [7:0]  swaps;

    modport master (
        input  start,
        input  mayor,
        output o_signal,
        output busy,
        output done,
        output swaps
    );

    modport slave (
        output start,
        output mayor,
        input  o_signal,
        input  busy,
        input  done,
        input  swaps
    );
endinterface

// File: rtl/sort_sequencer.sv
// Moore controller running an in-place bubble sort of R0..R(N-1) on the shared datapath.
// One cycle per compare, three more per swap; start is only accepted in IDLE.
module sort_sequencer #(
    parameter int          N       = 8,
    parameter logic [3:0]  TMP_REG = 4'd15
) (
    input  logic            clk,
    input  logic            rst,
    sort_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_SW0,
        S_SW1,
        S_SW2,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_INIT = 4'(N - 1);

    state_t     state_q, state_d;
    logic [3:0] i_q, i_d;
    logic [3:0] last_q, last_d;
    logic       swapped_q, swapped_d;
    logic [7:0] swaps_q, swaps_d;

    logic [3:0] i_nxt;
    logic       adv;
    logic [1:0] cnt_alu;
    logic [3:0] mux_a;
    logic [3:0] mux_b;
    logic [3:0] slc_reg;
    logic       w;

    assign i_nxt = i_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            i_q       <= 4'd0;
            last_q    <= 4'd0;
            swapped_q <= 1'b0;
            swaps_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            last_q    <= last_d;
            swapped_q <= swapped_d;
            swaps_q   <= swaps_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        last_d    = last_q;
        swapped_d = swapped_q;
        swaps_d   = swaps_q;
        adv       = 1'b0;
        cnt_alu   = 2'b00;
        mux_a     = 4'd0;
        mux_b     = 4'd0;
        slc_reg   = 4'd0;
        w         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    i_d       = 4'd0;
                    last_d    = LAST_INIT;
                    swapped_d = 1'b0;
                    swaps_d   = 8'd0;
                    state_d   = S_CMP;
                end
            end
            S_CMP: begin
                cnt_alu = 2'b01;
                mux_a   = i_q;
                mux_b   = i_nxt;
                if (bus.mayor) begin
                    state_d = S_SW0;
                end else begin
                    adv = 1'b1;
                end
            end
            S_SW0: begin
                mux_a   = i_q;
                slc_reg = TMP_REG;
                w       = 1'b1;
                state_d = S_SW1;
            end
            S_SW1: begin
                mux_a   = i_nxt;
                slc_reg = i_q;
                w       = 1'b1;
                state_d = S_SW2;
            end
            S_SW2: begin
                mux_a     = TMP_REG;
                slc_reg   = i_nxt;
                w         = 1'b1;
                swapped_d = 1'b1;
                swaps_d   = (swaps_q == 8'hFF) ? swaps_q : swaps_q + 8'd1;
                adv       = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // swapped_d already includes a swap completing this cycle in SW2
        if (adv) begin
            if (i_nxt < last_q) begin
                i_d     = i_nxt;
                state_d = S_CMP;
            end else if (!swapped_d || last_q == 4'd1) begin
                state_d = S_DONE;
            end else begin
                last_d    = last_q - 4'd1;
                i_d       = 4'd0;
                swapped_d = 1'b0;
                state_d   = S_CMP;
            end
        end
    end

    // Gating with rst keeps the datapath from writing during any reset cycle, even mid-swap.
    assign bus.o_signal = rst ? {cnt_alu, mux_a, mux_b, slc_reg, w} : 15'd0;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.swaps    = swaps_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: four instances (N=2,3,4,8), each with its own register-file model,
// checked cycle by cycle against a plain bubble-sort reference.
module tb_sort_sequencer;

    localparam int NI = 4;

    function automatic int nval(input int g);
        return (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 8;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        start_v;
    logic [NI-1:0]        busy_v;
    logic [NI-1:0]        done_v;
    logic [NI-1:0]        mayor_v;
    logic [NI-1:0][14:0]  osig_v;
    logic [NI-1:0][7:0]   swaps_v;

    logic [7:0] rf [NI][16];
    logic       ld_en = 1'b0;
    int         ld_sel = 0;
    logic [7:0] ld_vals [16];
    logic [7:0] cur_vals [16];

    int errors = 0;
    int checks = 0;
    int last_busy = 0;

    logic [14:0] exp_q[$];
    logic [7:0]  exp_arr [16];
    int          exp_swaps;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        sort_sequencer_if bus ();
        assign bus.start  = start_v[g];
        assign bus.mayor  = (bus.o_signal[14:13] == 2'b01) &&
                            (rf[g][bus.o_signal[12:9]] > rf[g][bus.o_signal[8:5]]);
        assign osig_v[g]  = bus.o_signal;
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign swaps_v[g] = bus.swaps;
        assign mayor_v[g] = bus.mayor;

        sort_sequencer #(.N(nval(g)), .TMP_REG(4'd15)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );
    end

    // Register file + pass-A ALU: a write copies R[mux_a] into R[slc_reg].
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (ld_en && ld_sel == g) begin
                for (int r = 0; r < 16; r++) rf[g][r] <= ld_vals[r];
            end else if (osig_v[g][0]) begin
                rf[g][osig_v[g][4:1]] <= rf[g][osig_v[g][12:9]];
            end
        end
    end

    function automatic logic [14:0] cw(input logic [1:0] alu, input int a, input int b,
                                       input int r, input logic w);
        return {alu, 4'(a), 4'(b), 4'(r), w};
    endfunction

    // Reference: textbook bubble sort with early exit, emitting one word per controller cycle.
    task automatic model(input int n);
        logic [7:0] a [16];
        bit sw;
        logic [7:0] t;
        a = cur_vals;
        exp_q.delete();
        exp_swaps = 0;
        for (int last = n - 1; last >= 1; last--) begin
            sw = 1'b0;
            for (int i = 0; i < last; i++) begin
                exp_q.push_back(cw(2'b01, i, i + 1, 0, 1'b0));
                if (a[i] > a[i + 1]) begin
                    exp_q.push_back(cw(2'b00, i, 0, 15, 1'b1));
                    exp_q.push_back(cw(2'b00, i + 1, 0, i, 1'b1));
                    exp_q.push_back(cw(2'b00, 15, 0, i + 1, 1'b1));
                    t = a[i];
                    a[15] = t;
                    a[i] = a[i + 1];
                    a[i + 1] = t;
                    sw = 1'b1;
                    if (exp_swaps < 255) exp_swaps++;
                end
            end
            if (!sw) break;
        end
        exp_q.push_back(15'd0);
        exp_arr = a;
    endtask

    task automatic load(input int sel);
        ld_vals = cur_vals;
        ld_sel  = sel;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic set_vals(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
        for (int r = 0; r < 16; r++) cur_vals[r] = 8'd0;
        cur_vals[0] = v0;
        cur_vals[1] = v1;
        cur_vals[2] = v2;
        cur_vals[3] = v3;
        cur_vals[15] = 8'd99;
    endtask

    task automatic run_sort(input int sel, input int n, input bit disturb, input string name);
        int len;
        bit bad;
        load(sel);
        model(n);
        len = exp_q.size();
        last_busy = 0;
        start_v[sel] = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            start_v[sel] = (disturb && k < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy_v[sel] === 1'b1) last_busy++;
            checks++;
            if (osig_v[sel] !== exp_q[k] || busy_v[sel] !== 1'b1 || done_v[sel] !== (k == len - 1)) begin
                errors++;
                $display("FAIL %s cycle %0d: o_signal=%h busy=%b done=%b, expected o_signal=%h busy=1 done=%b",
                         name, k, osig_v[sel], busy_v[sel], done_v[sel], exp_q[k], (k == len - 1));
            end
        end
        @(negedge clk);
        checks++;
        if (busy_v[sel] !== 1'b0 || done_v[sel] !== 1'b0 || swaps_v[sel] !== 8'(exp_swaps)) begin
            errors++;
            $display("FAIL %s end: busy=%b done=%b swaps=%0d, expected busy=0 done=0 swaps=%0d",
                     name, busy_v[sel], done_v[sel], swaps_v[sel], exp_swaps);
        end
        bad = 1'b0;
        for (int r = 0; r < 16; r++) if (rf[sel][r] !== exp_arr[r]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s regs: R0..R3=%0d,%0d,%0d,%0d R15=%0d, expected %0d,%0d,%0d,%0d R15=%0d", name,
                     rf[sel][0], rf[sel][1], rf[sel][2], rf[sel][3], rf[sel][15],
                     exp_arr[0], exp_arr[1], exp_arr[2], exp_arr[3], exp_arr[15]);
        end
    endtask

    task automatic check_busy(input string name, input int want);
        checks++;
        if (last_busy !== want) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", name, last_busy, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (osig_v[g] !== 15'd0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0 || swaps_v[g] !== 8'd0) begin
                errors++;
                $display("FAIL reset inst %0d: o_signal=%h busy=%b done=%b swaps=%0d, expected all 0",
                         g, osig_v[g], busy_v[g], done_v[g], swaps_v[g]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sorted();
        set_vals(8'd1, 8'd2, 8'd3, 8'd4);
        run_sort(2, 4, 1'b0, "sorted_n4");
        check_busy("sorted_n4", 4);
    endtask

    task automatic test_reverse();
        set_vals(8'd3, 8'd2, 8'd1, 8'd0);
        run_sort(1, 3, 1'b0, "reverse_n3");
        check_busy("reverse_n3", 13);
        for (int r = 0; r < 16; r++) cur_vals[r] = 8'd0;
        for (int r = 0; r < 8; r++) cur_vals[r] = 8'(200 - r);
        run_sort(3, 8, 1'b0, "reverse_n8");
        check_busy("reverse_n8", 113);
    endtask

    task automatic test_early_exit();
        set_vals(8'd2, 8'd1, 8'd3, 8'd4);
        run_sort(2, 4, 1'b0, "early_exit_n4");
        check_busy("early_exit_n4", 9);
    endtask

    task automatic test_start_ignored();
        set_vals(8'd2, 8'd1, 8'd3, 8'd4);
        run_sort(2, 4, 1'b1, "start_busy_n4");
        check_busy("start_busy_n4", 9);
        set_vals(8'd3, 8'd2, 8'd1, 8'd0);
        run_sort(1, 3, 1'b1, "start_busy_n3");
        check_busy("start_busy_n3", 13);
    endtask

    task automatic test_reset_mid_swap();
        set_vals(8'd3, 8'd2, 8'd1, 8'd0);
        cur_vals[15] = 8'd0;
        load(1);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (osig_v[1] !== cw(2'b00, 1, 0, 0, 1'b1)) begin
            errors++;
            $display("FAIL mid_swap in SW1: o_signal=%h, expected %h", osig_v[1], cw(2'b00, 1, 0, 0, 1'b1));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (osig_v[1] !== 15'd0) begin
            errors++;
            $display("FAIL mid_swap gated: o_signal=%h, expected 0", osig_v[1]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (osig_v[1] !== 15'd0 || busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || swaps_v[1] !== 8'd0) begin
                errors++;
                $display("FAIL mid_swap reset cycle %0d: o_signal=%h busy=%b done=%b swaps=%0d, expected all 0",
                         c, osig_v[1], busy_v[1], done_v[1], swaps_v[1]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_v[1] !== 1'b0 || rf[1][0] !== 8'd3 || rf[1][1] !== 8'd2 || rf[1][15] !== 8'd3) begin
            errors++;
            $display("FAIL mid_swap after release: busy=%b R0=%0d R1=%0d R15=%0d, expected busy=0 R0=3 R1=2 R15=3",
                     busy_v[1], rf[1][0], rf[1][1], rf[1][15]);
        end
        cur_vals[15] = 8'd3;
        run_sort(1, 3, 1'b0, "resort_n3");
    endtask

    task automatic test_held_start();
        logic [14:0] w_exp;
        bit b_exp, d_exp;
        set_vals(8'd5, 8'd5, 8'd0, 8'd0);
        load(0);
        start_v[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            w_exp = (k % 3 == 0) ? cw(2'b01, 0, 1, 0, 1'b0) : 15'd0;
            b_exp = (k % 3 != 2);
            d_exp = (k % 3 == 1);
            checks++;
            if (osig_v[0] !== w_exp || busy_v[0] !== b_exp || done_v[0] !== d_exp ||
                mayor_v[0] !== 1'b0 || swaps_v[0] !== 8'd0) begin
                errors++;
                $display("FAIL held_start cycle %0d: o_signal=%h busy=%b done=%b mayor=%b swaps=%0d, expected %h %b %b 0 0",
                         k, osig_v[0], busy_v[0], done_v[0], mayor_v[0], swaps_v[0], w_exp, b_exp, d_exp);
            end
        end
        start_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL held_start release: busy=%b, expected 0", busy_v[0]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 16; r++) cur_vals[r] = 8'($urandom_range(0, 15));
            run_sort(3, 8, (t % 2 == 1), "random_n8");
        end
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 16; r++) cur_vals[r] = 8'($urandom_range(0, 3));
            run_sort(2, 4, 1'b0, "random_n4");
        end
    endtask

    initial begin
        start_v = '0;
        for (int r = 0; r < 16; r++) ld_vals[r] = 8'd0;
        test_reset();
        test_sorted();
        test_reverse();
        test_early_exit();
        test_start_ignored();
        test_reset_mid_swap();
        test_held_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
